lfsr_step_ctrl: RTL and testbench
=================================

# lfsr_step_ctrl

Sequencing controller for the 8-bit random-number datapath. It owns an enable-gated copy of the team's shift LFSR, using the same feedback. It loads seeds and steps the LFSR on request or on a programmable periodic tick. Each new value is presented downstream through a valid/ready handshake, and its two nibbles are exported to the hex seven-segment decoders. It also prevents the all-zero lock-up state and flags ticks that arrive while a value is still unconsumed.

## Interface
- DIV_W, 16, width of the tick-period register
- DEFAULT_SEED, 8'h01, substitute seed when a zero seed is loaded; must be non-zero
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- seed_in  in  8  seed value, sampled with `load`
- load  in  1  seed-load request (single-cycle pulse)
- step_req  in  1  single-step request
- step_ack  out  1  one-cycle pulse: step_req accepted
- run  in  1  level; enables the periodic tick
- div  in  DIV_W  tick period minus one (0 = tick every cycle)
- rand_out  out  8  current LFSR value
- out_valid  out  1  rand_out holds a new, unconsumed value
- out_ready  in  1  downstream accepts the value
- hex_hi  out  4  rand_out[7:4], to the seven-segment decoder
- hex_lo  out  4  rand_out[3:0], to the seven-segment decoder
- busy  out  1  FSM not in IDLE
- overrun  out  1  sticky: a tick arrived while not in IDLE
- zero_fix  out  1  one-cycle pulse: zero seed replaced by DEFAULT_SEED

## Operation
- **LFSR next value:** next = {^{s[4],s[3],s[2],s[0]}, s[7:1]}.
  - Updates only in GEN (step) or at the end of LOAD (load).
- **FSM states:** IDLE, LOAD, GEN, WAIT_ACK.
- **IDLE**, requests resolved in priority order load > step_req > tick:
  - load → LOAD; seed_in is captured into seed_q.
  - step_req → GEN; step_ack pulses.
  - tick → GEN.
- **LOAD** (one cycle):
  - lfsr <= seed_q, or DEFAULT_SEED if seed_q == 0, in which case zero_fix pulses.
  - Next state is IDLE. out_valid stays 0.
- **GEN** (one cycle): lfsr <= next; next state is WAIT_ACK.
- **WAIT_ACK:**
  - out_valid = 1; rand_out is held stable.
  - out_ready → IDLE.
- **load outside IDLE:** aborts from any state.
  - The FSM goes to LOAD; out_valid drops the next cycle.
  - Any pending value is discarded.
- **step_req outside IDLE:** ignored; no step_ack. The requester must hold step_req until it sees step_ack.
- **Tick counter:**
  - Free-runs only while run = 1; cleared whenever run = 0 or on load.
  - Counts 0..div; tick = (count == div), then the count wraps to 0.
  - A tick outside IDLE is dropped and sets overrun.
  - overrun clears only on load or reset.
- **div changes:** take effect at the next wrap. If count > new div, the counter wraps at the all-ones value. This case is not a requirement for the bench.
- **Reset values:**
  - lfsr = DEFAULT_SEED, FSM = IDLE, count = 0.
  - step_ack, out_valid, overrun, zero_fix, busy = 0.
  - rand_out = DEFAULT_SEED.

## Timing
- All outputs are registered or decoded directly from registered state; there are no combinational input→output paths.
- **load:** sampled at edge k. The FSM is in LOAD after k; rand_out = seed after edge k+1.
- **Step:**
  - step_req sampled in IDLE at edge k → step_ack = 1 for the cycle after k.
  - New rand_out and out_valid = 1 after edge k+1, a latency of 2 clocks.
- **Consume:** out_ready sampled high at edge m while out_valid → out_valid = 0 after m. The earliest next step is then accepted at edge m+1.
- **Periodic throughput:** with run = 1 and out_ready tied high, the maximum rate is one value per 3 cycles. With div ≥ 2, there is one value per div+1 cycles and overrun never sets.
- **Same-edge conflicts:**
  - load and step_req together → load wins; no step_ack.
  - load and out_ready together in WAIT_ACK → load wins; the value is not counted as consumed.
- **Reset mid-operation:** asynchronous return to the reset values; no partial handshake survives.

## Structure
- **Shared package `rand_pkg`:**
  - FSM state enum: IDLE, LOAD, GEN, WAIT_ACK.
  - 8-bit LFSR width constant.
  - Feedback tap mask 8'b0001_1101.
  - Next-state function.
- **Sub-module `lfsr8_en`:**
  - Ports: clk, reset, load, load_val, step, q.
  - Same polynomial as the existing shift LFSR.
  - Adds an enable and a synchronous load.
- **Controller (`lfsr_step_ctrl`):** FSM, tick counter and handshake logic. The controller instantiates `lfsr8_en` once.

## Test plan
- Reset release → rand_out = 8'h01, out_valid = 0, busy = 0. Then step_req → step_ack one cycle later, rand_out = 8'h80 with out_valid two cycles after the request.
- Load 8'hA5, then step → 8'h52. Hold out_ready low for 5 cycles → rand_out and out_valid remain stable. Pulse out_ready → out_valid falls the next cycle.
- Load 8'h00 → zero_fix pulses once, rand_out = 8'h01. Four steps → 8'h80, 8'h40, 8'h20, 8'h10; a fifth step → 8'h88.
- run = 1, div = 4, out_ready tied high → one new value every 5 cycles, overrun stays 0. Then div = 0 → overrun sets; a subsequent load clears it.
- load asserted in WAIT_ACK together with out_ready → out_valid falls and rand_out = new seed; no extra step occurs. load and step_req in the same cycle → no step_ack.
- reset asserted during GEN → all outputs return to their reset values immediately, without a clock edge.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared definitions for the 8-bit random-number datapath: LFSR width,
// feedback taps, controller state encoding and the LFSR next-value function.
package rand_pkg;

  localparam int LFSR_W = 8;

  // Taps at bits 4, 3, 2 and 0; the XOR of these bits shifts in at the MSB.
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0001_1101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_GEN      = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & TAP_MASK), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr8_en.sv
// 8-bit right-shift LFSR with a synchronous load and a step enable.
// Load takes precedence over step; the register holds otherwise.
module lfsr8_en
  import rand_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_VAL = 8'h01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/lfsr_step_ctrl.sv
// Sequencing controller: seeds and steps the LFSR on request or on a periodic
// tick, and presents each new value through a valid/ready handshake.
module lfsr_step_ctrl
  import rand_pkg::*;
#(
  parameter int          DIV_W        = 16,
  parameter logic [7:0]  DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       seed_in,
  input  logic             load,
  input  logic             step_req,
  output logic             step_ack,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic [7:0]       rand_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       hex_hi,
  output logic [3:0]       hex_lo,
  output logic             busy,
  output logic             overrun,
  output logic             zero_fix,
  output logic [1:0]       state_dbg
);

  // Handshake: out_valid is high exactly while in WAIT_ACK and rand_out is
  // frozen there; a value is consumed on an edge where out_valid and
  // out_ready are both high, unless load arrives on that same edge.

  state_e             state;
  state_e             state_nxt;
  logic [7:0]         seed_q;
  logic [DIV_W-1:0]   count;
  logic               tick;
  logic               lfsr_load;
  logic               lfsr_step;
  logic [7:0]         load_val;
  logic [LFSR_W-1:0]  lfsr_q;

  assign tick      = run && (count == div);
  assign lfsr_load = (state == ST_LOAD);
  assign lfsr_step = (state == ST_GEN);
  assign load_val  = (seed_q == 8'h00) ? DEFAULT_SEED : seed_q;

  lfsr8_en #(
    .RESET_VAL(DEFAULT_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (lfsr_load),
    .load_val(load_val),
    .step    (lfsr_step),
    .q       (lfsr_q)
  );

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE:     if (step_req || tick) state_nxt = ST_GEN;
        ST_LOAD:     state_nxt = ST_IDLE;
        ST_GEN:      state_nxt = ST_WAIT_ACK;
        ST_WAIT_ACK: if (out_ready) state_nxt = ST_IDLE;
        default:     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      seed_q   <= 8'h00;
      step_ack <= 1'b0;
      zero_fix <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_ack <= !load && (state == ST_IDLE) && step_req;
      zero_fix <= lfsr_load && (seed_q == 8'h00);
      if (load) begin
        seed_q <= seed_in;
      end
    end
  end

  // Comparing with == only: if div shrinks below count, the counter runs on
  // to all-ones and wraps naturally before matching again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!run || load) begin
      count <= '0;
    end else if (count == div) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (load) begin
      overrun <= 1'b0;
    end else if (tick && (state != ST_IDLE)) begin
      overrun <= 1'b1;
    end
  end

  assign rand_out  = lfsr_q;
  assign hex_hi    = lfsr_q[7:4];
  assign hex_lo    = lfsr_q[3:0];
  assign out_valid = (state == ST_WAIT_ACK);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Self-checking bench for lfsr_step_ctrl: directed scenarios plus a random
// load/step mix checked against a behavioural LFSR model.
module tb_lfsr_step_ctrl;

  localparam int DIV_W = 16;

  logic             clk;
  logic             reset;
  logic [7:0]       seed_in;
  logic             load;
  logic             step_req;
  logic             step_ack;
  logic             run;
  logic [DIV_W-1:0] div;
  logic [7:0]       rand_out;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       hex_hi;
  logic [3:0]       hex_lo;
  logic             busy;
  logic             overrun;
  logic             zero_fix;
  logic [1:0]       state_dbg;

  int         vectors;
  int         miscompares;
  logic [7:0] model_val;

  lfsr_step_ctrl #(
    .DIV_W       (DIV_W),
    .DEFAULT_SEED(8'h01)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .seed_in  (seed_in),
    .load     (load),
    .step_req (step_req),
    .step_ack (step_ack),
    .run      (run),
    .div      (div),
    .rand_out (rand_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .hex_hi   (hex_hi),
    .hex_lo   (hex_lo),
    .busy     (busy),
    .overrun  (overrun),
    .zero_fix (zero_fix),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: shift right by one, the XOR of bits 4,3,2,0 enters at bit 7
  function automatic logic [7:0] model_next(input logic [7:0] v);
    int fb;
    int r;
    fb = (v[4] + v[3] + v[2] + v[0]) % 2;
    r  = (int'(v) / 2) + fb * 128;
    return r[7:0];
  endfunction

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] s);
    load    = 1'b1;
    seed_in = s;
    cyc(1);
    load = 1'b0;
    cyc(1);
  endtask

  task automatic do_step(output logic ack, output logic v, output logic [7:0] val);
    step_req = 1'b1;
    cyc(1);
    ack      = step_ack;
    step_req = 1'b0;
    cyc(1);
    v   = out_valid;
    val = rand_out;
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; seed_in = 8'h00; load = 1'b0; step_req = 1'b0;
    run = 1'b0; div = '0; out_ready = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    model_val = 8'h01;
    vectors++; if (rand_out !== 8'h01) begin miscompares++; $display("FAIL reset_rand_out: got %h expected %h", rand_out, 8'h01); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (step_ack !== 1'b0) begin miscompares++; $display("FAIL reset_step_ack: got %b expected 0", step_ack); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    vectors++; if (zero_fix !== 1'b0) begin miscompares++; $display("FAIL reset_zero_fix: got %b expected 0", zero_fix); end
    vectors++; if ({hex_hi, hex_lo} !== 8'h01) begin miscompares++; $display("FAIL reset_hex: got %h%h expected 01", hex_hi, hex_lo); end
  endtask

  task automatic test_step();
    step_req = 1'b1;
    cyc(1);
    vectors++; if (step_ack !== 1'b1) begin miscompares++; $display("FAIL step_ack_pulse: got %b expected 1", step_ack); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL step_valid_early: got %b expected 0", out_valid); end
    step_req = 1'b0;
    cyc(1);
    model_val = model_next(model_val);
    vectors++; if (step_ack !== 1'b0) begin miscompares++; $display("FAIL step_ack_width: got %b expected 0", step_ack); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL step_valid: got %b expected 1", out_valid); end
    vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL step_value: got %h expected %h", rand_out, model_val); end
    vectors++; if ({hex_hi, hex_lo} !== model_val) begin miscompares++; $display("FAIL step_hex: got %h%h expected %h", hex_hi, hex_lo, model_val); end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL step_consume: got %b expected 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL step_idle: got %b expected 0", busy); end
  endtask

  task automatic test_load_stall();
    do_load(8'hA5);
    model_val = 8'hA5;
    vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL load_value: got %h expected %h", rand_out, model_val); end
    vectors++; if (zero_fix !== 1'b0) begin miscompares++; $display("FAIL load_zero_fix: got %b expected 0", zero_fix); end
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    cyc(1);
    model_val = model_next(model_val);
    for (int i = 0; i < 5; i++) begin
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
      vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL stall_value[%0d]: got %h expected %h", i, rand_out, model_val); end
      cyc(1);
    end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release: got %b expected 0", out_valid); end
  endtask

  task automatic test_zero_seed();
    logic       ack;
    logic       v;
    logic [7:0] val;
    load = 1'b1; seed_in = 8'h00;
    cyc(1);
    load = 1'b0;
    vectors++; if (zero_fix !== 1'b0) begin miscompares++; $display("FAIL zero_fix_early: got %b expected 0", zero_fix); end
    cyc(1);
    model_val = 8'h01;
    vectors++; if (zero_fix !== 1'b1) begin miscompares++; $display("FAIL zero_fix_pulse: got %b expected 1", zero_fix); end
    vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL zero_seed_value: got %h expected %h", rand_out, model_val); end
    cyc(1);
    vectors++; if (zero_fix !== 1'b0) begin miscompares++; $display("FAIL zero_fix_width: got %b expected 0", zero_fix); end
    for (int i = 0; i < 5; i++) begin
      do_step(ack, v, val);
      model_val = model_next(model_val);
      vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL zero_step_ack[%0d]: got %b expected 1", i, ack); end
      vectors++; if (v !== 1'b1) begin miscompares++; $display("FAIL zero_step_valid[%0d]: got %b expected 1", i, v); end
      vectors++; if (val !== model_val) begin miscompares++; $display("FAIL zero_step_value[%0d]: got %h expected %h", i, val, model_val); end
    end
  endtask

  task automatic test_periodic();
    int  div_v;
    logic exp_v;
    div_v = 4;
    div = DIV_W'(div_v);
    out_ready = 1'b1;
    run = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      cyc(1);
      exp_v = (i >= div_v + 2) && (((i - (div_v + 2)) % (div_v + 1)) == 0);
      vectors++; if (out_valid !== exp_v) begin miscompares++; $display("FAIL periodic_valid[%0d]: got %b expected %b", i, out_valid, exp_v); end
      if (exp_v) begin
        model_val = model_next(model_val);
        vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL periodic_value[%0d]: got %h expected %h", i, rand_out, model_val); end
      end
    end
    run = 1'b0;
    cyc(3);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL periodic_overrun: got %b expected 0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL periodic_idle: got %b expected 0", busy); end
    div = '0;
    run = 1'b1;
    cyc(4);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    run = 1'b0;
    cyc(3);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
    out_ready = 1'b0;
    do_load(8'h5A);
    model_val = 8'h5A;
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_clear: got %b expected 0", overrun); end
    vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL overrun_load_value: got %h expected %h", rand_out, model_val); end
  endtask

  task automatic test_load_conflicts();
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    cyc(1);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL conflict_pre_valid: got %b expected 1", out_valid); end
    load = 1'b1; seed_in = 8'h3C; out_ready = 1'b1;
    cyc(1);
    load = 1'b0; out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL conflict_valid_drop: got %b expected 0", out_valid); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL conflict_in_load: got %b expected 1", busy); end
    cyc(1);
    model_val = 8'h3C;
    vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL conflict_seed: got %h expected %h", rand_out, model_val); end
    cyc(2);
    vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL conflict_no_step: got %h expected %h", rand_out, model_val); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL conflict_no_valid: got %b expected 0", out_valid); end
    load = 1'b1; step_req = 1'b1; seed_in = 8'hC3;
    cyc(1);
    load = 1'b0; step_req = 1'b0;
    vectors++; if (step_ack !== 1'b0) begin miscompares++; $display("FAIL load_step_ack: got %b expected 0", step_ack); end
    cyc(1);
    model_val = 8'hC3;
    vectors++; if (step_ack !== 1'b0) begin miscompares++; $display("FAIL load_step_ack_late: got %b expected 0", step_ack); end
    vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL load_step_seed: got %h expected %h", rand_out, model_val); end
    cyc(1);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL load_step_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    int         op;
    int         d;
    logic [7:0] s;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        load = 1'b1; seed_in = s;
        cyc(1);
        load = 1'b0;
        cyc(1);
        model_val = (s == 8'h00) ? 8'h01 : s;
        vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL rnd_load[%0d]: got %h expected %h", n, rand_out, model_val); end
        vectors++; if (zero_fix !== (s == 8'h00)) begin miscompares++; $display("FAIL rnd_zero_fix[%0d]: got %b expected %b", n, zero_fix, (s == 8'h00)); end
      end else begin
        d = $urandom_range(0, 3);
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0;
        vectors++; if (step_ack !== 1'b1) begin miscompares++; $display("FAIL rnd_ack[%0d]: got %b expected 1", n, step_ack); end
        cyc(1);
        model_val = model_next(model_val);
        for (int k = 0; k <= d; k++) begin
          vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b expected 1", n, out_valid); end
          vectors++; if (rand_out !== model_val) begin miscompares++; $display("FAIL rnd_value[%0d]: got %h expected %h", n, rand_out, model_val); end
          if (k < d) cyc(1);
        end
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_consume[%0d]: got %b expected 0", n, out_valid); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_load(8'hA5);
    div = '0; run = 1'b1; out_ready = 1'b1;
    cyc(4);
    run = 1'b0;
    cyc(3);
    out_ready = 1'b0;
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL areset_pre_overrun: got %b expected 1", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_pre_idle: got %b expected 0", busy); end
    step_req = 1'b1;
    cyc(1);
    step_req = 1'b0;
    vectors++; if (step_ack !== 1'b1) begin miscompares++; $display("FAIL areset_pre_ack: got %b expected 1", step_ack); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (rand_out !== 8'h01) begin miscompares++; $display("FAIL areset_rand_out: got %h expected 01", rand_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b expected 0", busy); end
    vectors++; if (step_ack !== 1'b0) begin miscompares++; $display("FAIL areset_step_ack: got %b expected 0", step_ack); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL areset_overrun: got %b expected 0", overrun); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
    cyc(1);
    reset = 1'b1;
    cyc(2);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_after_valid: got %b expected 0", out_valid); end
    vectors++; if (rand_out !== 8'h01) begin miscompares++; $display("FAIL areset_after_value: got %h expected 01", rand_out); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_step();
    test_load_stall();
    test_zero_seed();
    test_periodic();
    test_load_conflicts();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
